fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage for the RISC-V core.
- Sits directly upstream of Main_Decoder, which receives `instr[6:0]` as `opCode`.
- Owns the PC register and the fetch handshake with instruction memory.
- Resolves the next PC from Main_Decoder's `branch`/`jump`, the ALU `zero` flag and the sign-extended immediate.
- Holds each instruction stable until the core retires it; traps on a misaligned control-flow target.

Parameters:
- XLEN, 32, datapath and PC width in bits.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address; always equals `pc` while `imem_req`=1.
- imem_ready  in  1  memory has returned `imem_rdata` this cycle (sampled only when `imem_req`=1).
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction; bits [6:0] drive Main_Decoder `opCode`.
- instr_valid  out  1  `instr` is valid and held for the core.
- pc  out  XLEN  address of the current `instr`.
- pc_plus4  out  XLEN  `pc`+4, used for the JAL link writeback.
- retire  in  1  core has finished the current instruction this cycle.
- branch  in  1  from Main_Decoder.
- jump  in  1  from Main_Decoder.
- zero  in  1  ALU zero flag.
- imm_ext  in  XLEN  sign-extended immediate from the extend unit.
- misalign_trap  out  1  sticky; a taken target was not 4-byte aligned.

Behaviour:
- States: RESET_WAIT, FETCH, HOLD, TRAP (2-bit encoded).
- Reset values (async, `rst_n`=0):
  - state=RESET_WAIT, pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - instr_valid=0, imem_req=0, misalign_trap=0.
  - imem_addr and pc_plus4 track pc combinationally.
- RESET_WAIT: one cycle after reset deassertion -> FETCH. This keeps the first request off the reset-release edge.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 -> capture imem_rdata into instr, set instr_valid=1, go to HOLD.
  - Otherwise remain in FETCH with address stable. Wait is unbounded; there is no timeout.
- HOLD:
  - imem_req=0; instr, pc and instr_valid=1 are held stable.
  - `retire`=0 -> remain in HOLD.
  - `retire`=1 -> compute pc_src = (branch & zero) | jump.
    - next = pc_src ? pc + imm_ext : pc + 4.
    - Addition is modulo 2^XLEN: wrap-around is legal and silent.
  - If next[1:0] != 2'b00 -> TRAP, set misalign_trap=1, clear instr_valid, pc unchanged.
  - Else pc<=next, clear instr_valid, go to FETCH.
- Minimum instruction period: FETCH with immediate ready (1 cycle) + HOLD with immediate retire (1 cycle) = 2 cycles.
- `retire` outside HOLD is ignored.
- branch/jump/zero/imm_ext are sampled only on the retiring edge.
- branch=1 and jump=1 together: treated as taken (jump dominates).
- TRAP:
  - imem_req=0, instr_valid=0, pc frozen at the faulting instruction.
  - Exit only via reset.
- imem_ready while imem_req=0 is ignored.
- Reset asserted mid-FETCH or mid-HOLD: immediate return to reset values. No request is held across reset.
- Combinational paths:
  - imem_addr and pc_plus4 from pc only.
  - No combinational path from imem_ready or retire to any output.

Test Plan:
- Reset with RESET_PC=32'h0, imem_ready tied 1, retire tied 1:
  - first imem_req on cycle 2 after release, with addr 0x0.
  - pc sequence 0x0, 0x4, 0x8, with one instruction every 2 cycles.
  - instr before the first fetch = 0x00000013.
- FETCH at pc=0x10, imem_ready held low 5 cycles then high with rdata=0x00A00093:
  - imem_addr stays 0x10 throughout.
  - instr=0x00A00093 and instr_valid=1 on the following edge.
- HOLD at pc=0x20 with branch=1, zero=1, imm_ext=-8 (0xFFFFFFF8), retire=1 -> next fetch address 0x18.
- Same case with zero=0 -> next fetch address 0x24.
- HOLD at pc=0x40 with jump=1, imm_ext=0x6, retire=1:
  - misalign_trap=1, pc stays 0x40.
  - imem_req stays 0 for 20 cycles.
  - Only rst_n=0 clears the trap.
- Wrap: pc=0xFFFFFFFC with no branch, retire=1 -> next fetch address 0x00000000, no trap.
- rst_n pulsed low mid-FETCH (imem_ready=0) -> imem_req drops in the same cycle, pc=RESET_PC, instr_valid=0, and fetch restarts per the first scenario.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch and PC-sequencing stage: owns the PC, fetches one
// instruction at a time and holds it until the core retires it. The next PC
// is resolved from branch/jump/zero/imm_ext on the retiring edge. A taken
// target that is not word-aligned parks the unit in a sticky trap state
// that only reset clears.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            retire,
    input  logic            branch,
    input  logic            jump,
    input  logic            zero,
    input  logic [XLEN-1:0] imm_ext,
    output logic            misalign_trap
);

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'b00,
        ST_FETCH      = 2'b01,
        ST_HOLD       = 2'b10,
        ST_TRAP       = 2'b11
    } state_e;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;
    logic            trap_q, trap_d;
    logic            pc_src_s;
    logic [XLEN-1:0] next_pc_s;

    // Next-PC candidate; only consumed on a retiring edge in HOLD.
    always_comb begin
        pc_src_s  = (branch & zero) | jump;
        next_pc_s = pc_src_s ? (pc_q + imm_ext) : (pc_q + PC_STEP);
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        trap_d        = trap_q;
        case (state_q)
            ST_RESET_WAIT: begin
                // Request is raised one edge after reset release.
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = ST_HOLD;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (retire) begin
                    instr_valid_d = 1'b0;
                    if (next_pc_s[1:0] != 2'b00) begin
                        // PC stays on the faulting instruction.
                        trap_d  = 1'b1;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d       = next_pc_s;
                        imem_req_d = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end else begin
                    imem_req_d = 1'b0;
                end
            end
            ST_TRAP: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                trap_d        = 1'b1;
            end
            default: begin
                state_d       = ST_RESET_WAIT;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET_WAIT;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            trap_q        <= trap_d;
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign pc            = pc_q;
    assign pc_plus4      = pc_q + PC_STEP;
    assign misalign_trap = trap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change and outputs are sampled on
// the falling clock edge, expected values are hand-computed constants.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] imm_ext;
    logic        misalign_trap;

    int checks_cnt;
    int failures_cnt;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .retire       (retire),
        .branch       (branch),
        .jump         (jump),
        .zero         (zero),
        .imm_ext      (imm_ext),
        .misalign_trap(misalign_trap)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt = checks_cnt + 1;
        if (obs !== exp) begin
            failures_cnt = failures_cnt + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Apply one retiring edge in HOLD with the given decode inputs.
    task automatic retire_with(input logic br, input logic jp, input logic z,
                               input logic [31:0] imm);
        branch  = br;
        jump    = jp;
        zero    = z;
        imm_ext = imm;
        retire  = 1'b1;
        @(negedge clk);
        retire  = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        zero    = 1'b0;
        imm_ext = 32'h0000_0000;
    endtask

    initial begin
        checks_cnt   = 0;
        failures_cnt = 0;
        rst_n        = 1'b0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0010_0093;
        retire       = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        zero         = 1'b0;
        imm_ext      = 32'h0000_0000;

        repeat (3) tick();
        check_eq("rst_req",   {31'd0, imem_req},      32'd0);
        check_eq("rst_pc",    pc,                     32'h0000_0000);
        check_eq("rst_instr", instr,                  32'h0000_0013);
        check_eq("rst_valid", {31'd0, instr_valid},   32'd0);
        check_eq("rst_trap",  {31'd0, misalign_trap}, 32'd0);
        check_eq("rst_pc4",   pc_plus4,               32'h0000_0004);
        check_eq("rst_addr",  imem_addr,              32'h0000_0000);

        // Back-to-back flow: ready and retire tied high.
        imem_ready = 1'b1;
        retire     = 1'b1;
        rst_n      = 1'b1;
        #1;
        check_eq("rel_req0", {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("s1_req",   {31'd0, imem_req},    32'd1);
        check_eq("s1_addr",  imem_addr,            32'h0000_0000);
        check_eq("s1_instr", instr,                32'h0000_0013);
        check_eq("s1_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_eq("s1_hold_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("s1_hold_instr", instr,                32'h0010_0093);
        check_eq("s1_hold_req",   {31'd0, imem_req},    32'd0);
        check_eq("s1_hold_pc",    pc,                   32'h0000_0000);
        tick();
        check_eq("s1_pc4",  pc,                32'h0000_0004);
        check_eq("s1_req4", {31'd0, imem_req}, 32'd1);
        tick();
        check_eq("s1_hold4", {31'd0, instr_valid}, 32'd1);
        tick();
        check_eq("s1_pc8", imem_addr, 32'h0000_0008);
        retire = 1'b0;
        tick();
        check_eq("hold8_valid", {31'd0, instr_valid}, 32'd1);

        // Jump to 0x10, then stall the fetch for five cycles.
        retire_with(1'b0, 1'b1, 1'b0, 32'h0000_0008);
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_addr", imem_addr,         32'h0000_0010);
            check_eq("stall_req",  {31'd0, imem_req}, 32'd1);
            tick();
        end
        check_eq("stall_addr_end", imem_addr, 32'h0000_0010);
        imem_ready = 1'b1;
        imem_rdata = 32'h00A0_0093;
        tick();
        check_eq("stall_instr", instr,                32'h00A0_0093);
        check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("stall_pc",    pc,                   32'h0000_0010);

        // Branch taken from 0x20 by -8.
        retire_with(1'b0, 1'b1, 1'b0, 32'h0000_0010);
        check_eq("to20", imem_addr, 32'h0000_0020);
        tick();
        retire_with(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        check_eq("br_taken",     imem_addr,         32'h0000_0018);
        check_eq("br_taken_req", {31'd0, imem_req}, 32'd1);

        // Branch not taken from 0x20.
        tick();
        retire_with(1'b0, 1'b1, 1'b0, 32'h0000_0008);
        check_eq("back20", imem_addr, 32'h0000_0020);
        tick();
        retire_with(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8);
        check_eq("br_not_taken", imem_addr, 32'h0000_0024);

        // Branch and jump together with zero=0: jump dominates.
        tick();
        retire_with(1'b1, 1'b1, 1'b0, 32'h0000_001C);
        check_eq("br_jmp", imem_addr, 32'h0000_0040);

        // Wrap from 0xFFFFFFFC to 0.
        tick();
        retire_with(1'b0, 1'b1, 1'b0, 32'hFFFF_FFBC);
        check_eq("wrap_pc",  pc,       32'hFFFF_FFFC);
        check_eq("wrap_pc4", pc_plus4, 32'h0000_0000);
        tick();
        retire_with(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        check_eq("wrap_addr", imem_addr,              32'h0000_0000);
        check_eq("wrap_trap", {31'd0, misalign_trap}, 32'd0);
        check_eq("wrap_req",  {31'd0, imem_req},      32'd1);

        // Back to 0x40; retire during FETCH is ignored.
        tick();
        retire_with(1'b0, 1'b1, 1'b0, 32'h0000_0040);
        imem_ready = 1'b0;
        retire     = 1'b1;
        jump       = 1'b1;
        imm_ext    = 32'h0000_0100;
        tick();
        check_eq("fetch_retire_pc",  pc,                32'h0000_0040);
        check_eq("fetch_retire_req", {31'd0, imem_req}, 32'd1);
        retire     = 1'b0;
        jump       = 1'b0;
        imm_ext    = 32'h0000_0000;
        imem_ready = 1'b1;
        tick();
        check_eq("hold40_valid", {31'd0, instr_valid}, 32'd1);

        // Misaligned jump target traps.
        retire_with(1'b0, 1'b1, 1'b0, 32'h0000_0006);
        check_eq("trap_flag",  {31'd0, misalign_trap}, 32'd1);
        check_eq("trap_pc",    pc,                     32'h0000_0040);
        check_eq("trap_valid", {31'd0, instr_valid},   32'd0);
        retire = 1'b1;
        jump   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("trap_req", {31'd0, imem_req}, 32'd0);
        end
        check_eq("trap_sticky", {31'd0, misalign_trap}, 32'd1);
        check_eq("trap_pc_end", pc,                     32'h0000_0040);
        retire = 1'b0;
        jump   = 1'b0;

        // Reset clears the trap.
        rst_n = 1'b0;
        #1;
        check_eq("trap_clr", {31'd0, misalign_trap}, 32'd0);
        check_eq("trap_clr_pc", pc, 32'h0000_0000);
        tick();
        imem_ready = 1'b0;
        rst_n      = 1'b1;
        tick();
        tick();
        check_eq("pre_rst_req", {31'd0, imem_req}, 32'd1);

        // Reset pulsed mid-FETCH drops the request at once.
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_req",   {31'd0, imem_req},    32'd0);
        check_eq("midrst_pc",    pc,                   32'h0000_0000);
        check_eq("midrst_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        imem_ready = 1'b1;
        retire     = 1'b1;
        imem_rdata = 32'h0020_0113;
        rst_n      = 1'b1;
        tick();
        check_eq("re_req",  {31'd0, imem_req}, 32'd1);
        check_eq("re_addr", imem_addr,         32'h0000_0000);
        tick();
        check_eq("re_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("re_instr", instr,                32'h0020_0113);
        tick();
        check_eq("re_pc4", pc, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
